// File: rtl/mbssoc_ram_arb_pkg.sv
// Shared definitions for the SoC RAM arbiter: default widths, FSM state encoding
// and requester ids.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbssoc_ram_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_RD_ADDR = 3'd1,
        ARB_RD_DATA = 3'd2,
        ARB_WR      = 3'd3,
        ARB_DONE    = 3'd4
    } arb_state_e;

    localparam logic ARB_ID_IF = 1'b0;
    localparam logic ARB_ID_D  = 1'b1;

endpackage

// File: rtl/mbssoc_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not
// granted last wins.
module mbssoc_rr_pick2
    import mbssoc_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       id
);

    // Winner selection
    always_comb begin
        grant = |req;
        if (req == 2'b11) begin
            id = ~last;
        end else if (req[1]) begin
            id = ARB_ID_D;
        end else begin
            id = ARB_ID_IF;
        end
    end

endmodule

// File: rtl/mbssoc_ram_arb.sv
// Fetch/data arbiter and sequencer for the shared SoC RAM: registered address,
// tristated data bus and one-cycle we/re strobes, round-robin between requesters.
module mbssoc_ram_arb
    import mbssoc_ram_arb_pkg::*;
#(
    parameter int AW = `ADDR_WIDTH,
    parameter int DW = `DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          ram_we_q, ram_we_d;
    logic          ram_re_q, ram_re_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          pick_grant;
    logic          pick_id;

    mbssoc_rr_pick2 u_pick (
        .req   ({d_req, if_req}),
        .last  (last_q),
        .grant (pick_grant),
        .id    (pick_id)
    );

    // State and transaction latch register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= ARB_ID_D;
            id_q    <= ARB_ID_IF;
            addr_q  <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_grant) begin
                    id_d    = pick_id;
                    last_d  = pick_id;
                    addr_d  = (pick_id == ARB_ID_D) ? d_addr : if_addr;
                    wdata_d = d_wdata;
                    if ((pick_id == ARB_ID_D) && d_we) begin
                        state_d = ARB_WR;
                    end else begin
                        state_d = ARB_RD_ADDR;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_RD_ADDR: state_d = ARB_RD_DATA;
            ARB_RD_DATA: state_d = ARB_DONE;
            ARB_WR:      state_d = ARB_DONE;
            ARB_DONE:    state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop
    always_comb begin
        ram_we_d = (state_d == ARB_WR);
        ram_re_d = (state_d == ARB_RD_DATA);
        if ((state_d == ARB_RD_ADDR) || (state_d == ARB_WR)) begin
            ram_addr_d = addr_d;
        end else begin
            ram_addr_d = ram_addr_q;
        end
        if_ack_d = (state_d == ARB_DONE) && (id_d == ARB_ID_IF);
        d_ack_d  = (state_d == ARB_DONE) && (id_d == ARB_ID_D);
        if ((state_q == ARB_RD_DATA) && (id_q == ARB_ID_IF)) begin
            if_rdata_d = ram_data;
        end else begin
            if_rdata_d = if_rdata_q;
        end
        if ((state_q == ARB_RD_DATA) && (id_q == ARB_ID_D)) begin
            d_rdata_d = ram_data;
        end else begin
            d_rdata_d = d_rdata_q;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            ram_addr_q <= {AW{1'b0}};
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= {DW{1'b0}};
            d_rdata_q  <= {DW{1'b0}};
        end else begin
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            ram_addr_q <= ram_addr_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // The arbiter owns the bus only while the write strobe is up
    assign ram_data = ram_we_q ? wdata_q : {DW{1'bz}};

    assign ram_we   = ram_we_q;
    assign ram_re   = ram_re_q;
    assign ram_addr = ram_addr_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mbssoc_ram_arb.sv
// Self-checking bench for mbssoc_ram_arb: RAM model with registered read address,
// scoreboard queues per requester, directed scenarios and a random mix.
module tb_mbssoc_ram_arb;
    import mbssoc_ram_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          rd;
        logic [DW-1:0] data;
    } d_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] shadow [0:255];
    logic [7:0]    ram_raddr_q = 8'd0;
    logic          pl_en = 1'b0;
    logic [7:0]    pl_idx = 8'd0;
    logic [DW-1:0] pl_data = '0;

    logic [DW-1:0] if_q [$];
    d_exp_t        d_q [$];
    logic          ack_log [$];
    int            tests = 0;
    int            fails = 0;
    int            d_ack_cnt = 0;

    always #5 clk = ~clk;

    mbssoc_ram_arb #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    // RAM model: word-indexed, registered read address, output enabled by ram_re
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (ram_we) mem[ram_addr[9:2]] <= ram_data;
        ram_raddr_q <= ram_addr[9:2];
    end
    assign ram_data = ram_re ? mem[ram_raddr_q] : {DW{1'bz}};

    task automatic monitor();
        logic [DW-1:0] e;
        d_exp_t        de;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                tests++;
                if (ram_we && ram_re) begin
                    fails++;
                    $display("FAIL bus_we_re: ram_we=%b ram_re=%b, required never both high", ram_we, ram_re);
                end
                if (ram_re) begin
                    tests++;
                    if (ram_data !== mem[ram_raddr_q]) begin
                        fails++;
                        $display("FAIL bus_read_fight: ram_data=%h, required RAM word %h", ram_data, mem[ram_raddr_q]);
                    end
                end
                if (if_ack || d_ack) begin
                    tests++;
                    if (if_ack && d_ack) begin
                        fails++;
                        $display("FAIL ack_overlap: if_ack=%b d_ack=%b, required at most one", if_ack, d_ack);
                    end
                end
                if (if_ack) begin
                    ack_log.push_back(1'b0);
                    tests++;
                    if (if_q.size() == 0) begin
                        fails++;
                        $display("FAIL if_extra_ack: if_ack=1 with no outstanding fetch, required 0");
                    end else begin
                        e = if_q.pop_front();
                        if (if_rdata !== e) begin
                            fails++;
                            $display("FAIL if_rdata_sb: got %h, required %h", if_rdata, e);
                        end
                    end
                end
                if (d_ack) begin
                    d_ack_cnt++;
                    ack_log.push_back(1'b1);
                    tests++;
                    if (d_q.size() == 0) begin
                        fails++;
                        $display("FAIL d_extra_ack: d_ack=1 with no outstanding data access, required 0");
                    end else begin
                        de = d_q.pop_front();
                        if (de.rd && (d_rdata !== de.data)) begin
                            fails++;
                            $display("FAIL d_rdata_sb: got %h, required %h", d_rdata, de.data);
                        end
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle. lat = cycles after the first.
    task automatic if_txn(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                          output int lat, output logic [7:0] re_m, output logic [7:0] we_m);
        if_q.push_back(exp);
        if_addr = addr;
        if_req = 1'b1;
        lat = 0;
        re_m = 8'h00;
        we_m = 8'h00;
        re_m[0] = ram_re;
        we_m[0] = ram_we;
        while (1'b1) begin
            @(negedge clk);
            lat++;
            if (lat < 8) begin
                re_m[lat] = ram_re;
                we_m[lat] = ram_we;
            end
            if (if_ack) break;
            if (lat >= 60) begin
                tests++;
                fails++;
                $display("FAIL if_timeout: no if_ack after %0d cycles, required within 60", lat);
                break;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp, output int lat,
                         output logic [7:0] re_m, output logic [7:0] we_m);
        d_exp_t de;
        de.rd = ~we;
        de.data = exp;
        d_q.push_back(de);
        d_we = we;
        d_addr = addr;
        d_wdata = wdata;
        d_req = 1'b1;
        lat = 0;
        re_m = 8'h00;
        we_m = 8'h00;
        re_m[0] = ram_re;
        we_m[0] = ram_we;
        while (1'b1) begin
            @(negedge clk);
            lat++;
            if (lat < 8) begin
                re_m[lat] = ram_re;
                we_m[lat] = ram_we;
            end
            if (we && ram_we) begin
                tests++;
                if (ram_data !== wdata) begin
                    fails++;
                    $display("FAIL wr_bus: ram_data=%h during write, required %h", ram_data, wdata);
                end
            end
            if (d_ack) break;
            if (lat >= 60) begin
                tests++;
                fails++;
                $display("FAIL d_timeout: no d_ack after %0d cycles, required within 60", lat);
                break;
            end
        end
        d_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({ram_we, ram_re, if_ack, d_ack} !== 4'b0000) begin
            fails++;
            $display("FAIL %s_strobes: we,re,if_ack,d_ack=%b, required 0000", tag, {ram_we, ram_re, if_ack, d_ack});
        end
        tests++;
        if (ram_addr !== 32'h0) begin
            fails++;
            $display("FAIL %s_ram_addr: got %h, required 0", tag, ram_addr);
        end
        tests++;
        if ((if_rdata !== 32'h0) || (d_rdata !== 32'h0)) begin
            fails++;
            $display("FAIL %s_rdata: if_rdata=%h d_rdata=%h, required 0/0", tag, if_rdata, d_rdata);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1;
            pl_idx = 8'(i);
            pl_data = (i == 3) ? 32'hDEADBEEF : $urandom;
            shadow[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int lat;
        int d_before;
        logic [7:0] rm, wm;
        @(negedge clk);
        d_before = d_ack_cnt;
        if_txn(32'h0000_000C, 32'hDEADBEEF, lat, rm, wm);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL rd_latency: ack in cycle %0d, required 4", lat + 1); end
        tests++;
        if (rm !== 8'b0000_0100) begin fails++; $display("FAIL rd_re_window: ram_re per cycle %b, required 00000100", rm); end
        tests++;
        if (wm !== 8'h00) begin fails++; $display("FAIL rd_no_we: ram_we per cycle %b, required 0", wm); end
        tests++;
        if (if_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h, required deadbeef", if_rdata); end
        @(negedge clk);
        tests++;
        if (d_ack_cnt !== d_before) begin fails++; $display("FAIL rd_no_d_ack: %0d d_acks, required 0", d_ack_cnt - d_before); end
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] rm, wm;
        @(negedge clk);
        shadow[4] = 32'h12345678;
        d_txn(1'b1, 32'h0000_0010, 32'h12345678, 32'h0, lat, rm, wm);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL wr_latency: ack in cycle %0d, required 3", lat + 1); end
        tests++;
        if (wm !== 8'b0000_0010) begin fails++; $display("FAIL wr_we_window: ram_we per cycle %b, required 00000010", wm); end
        tests++;
        if (rm !== 8'h00) begin fails++; $display("FAIL wr_no_re: ram_re per cycle %b, required 0", rm); end
        @(negedge clk);
        d_txn(1'b0, 32'h0000_0010, 32'h0, 32'h12345678, lat, rm, wm);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL drd_latency: ack in cycle %0d, required 4", lat + 1); end
        tests++;
        if (d_rdata !== 32'h12345678) begin fails++; $display("FAIL drd_data: got %h, required 12345678", d_rdata); end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        @(negedge clk);
        ack_log.delete();
        fork
            begin
                int l; logic [7:0] r, w;
                if_txn(32'h0000_0040, shadow[16], l, r, w);
                if_txn(32'h0000_0044, shadow[17], l, r, w);
            end
            begin
                int l; logic [7:0] r, w;
                d_txn(1'b0, 32'h0000_0048, 32'h0, shadow[18], l, r, w);
                d_txn(1'b0, 32'h0000_004C, 32'h0, shadow[19], l, r, w);
            end
            begin
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        @(negedge clk);
        tests++;
        if ((ack_log.size() != 4) || (ack_log[0] !== 1'b0) || (ack_log[1] !== 1'b1) ||
            (ack_log[2] !== 1'b0) || (ack_log[3] !== 1'b1)) begin
            fails++;
            $display("FAIL rr_order: %0d acks, order %p, required IF,D,IF,D (0,1,0,1)", ack_log.size(), ack_log);
        end
    endtask

    task automatic test_hazard();
        logic [DW-1:0] old;
        int lat;
        logic [7:0] rm, wm;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack_log.delete();
        old = shadow[8];
        fork
            begin
                int l; logic [7:0] r, w;
                if_txn(32'h0000_0020, old, l, r, w);
                tests++;
                if (if_rdata !== old) begin fails++; $display("FAIL hz_old: got %h, required %h", if_rdata, old); end
            end
            begin
                int l; logic [7:0] r, w;
                d_txn(1'b1, 32'h0000_0020, 32'hA5A5A5A5, 32'h0, l, r, w);
            end
        join
        shadow[8] = 32'hA5A5A5A5;
        tests++;
        if ((ack_log.size() == 0) || (ack_log[0] !== 1'b0)) begin
            fails++;
            $display("FAIL hz_first: first ack from %p, required IF (0)", ack_log);
        end
        @(negedge clk);
        if_txn(32'h0000_0020, 32'hA5A5A5A5, lat, rm, wm);
        tests++;
        if (if_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL hz_new: got %h, required a5a5a5a5", if_rdata); end
    endtask

    task automatic test_random_mix();
        fork
            begin
                int l; logic [7:0] r, w;
                logic [AW-1:0] a;
                int wd;
                for (int n = 0; n < 800; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    wd = $urandom_range(0, 31);
                    a = '0;
                    a[9:2] = 8'(wd);
                    a[1:0] = 2'($urandom_range(0, 3));
                    if_txn(a, shadow[wd], l, r, w);
                end
            end
            begin
                int l; logic [7:0] r, w;
                logic [AW-1:0] a;
                logic [DW-1:0] v;
                int wd;
                for (int n = 0; n < 800; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    wd = $urandom_range(64, 127);
                    a = '0;
                    a[9:2] = 8'(wd);
                    a[1:0] = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) begin
                        v = $urandom;
                        shadow[wd] = v;
                        d_txn(1'b1, a, v, 32'h0, l, r, w);
                    end else begin
                        d_txn(1'b0, a, 32'h0, shadow[wd], l, r, w);
                    end
                end
            end
        join
        repeat (2) @(negedge clk);
        tests++;
        if ((if_q.size() != 0) || (d_q.size() != 0)) begin
            fails++;
            $display("FAIL mix_unacked: %0d fetch and %0d data left without ack, required 0/0", if_q.size(), d_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        logic found;
        logic [DW-1:0] old;
        int lat;
        logic [7:0] rm, wm;
        @(negedge clk);
        old = shadow[12];
        found = 1'b0;
        d_we = 1'b1;
        d_addr = 32'h0000_0030;
        d_wdata = 32'h0BADF00D;
        d_req = 1'b1;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clk);
            if (ram_we) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL rmw_no_wr: ram_we never seen, required within 10 cycles"); end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rmw_async");
        d_req = 1'b0;
        d_we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (d_ack !== 1'b0) begin fails++; $display("FAIL rmw_no_ack: d_ack=%b in reset, required 0", d_ack); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        d_txn(1'b0, 32'h0000_0030, 32'h0, old, lat, rm, wm);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL rmw_idle: read ack in cycle %0d after reset, required 4", lat + 1); end
        tests++;
        if (d_rdata !== old) begin fails++; $display("FAIL rmw_not_written: got %h, required old %h", d_rdata, old); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_hazard();
        test_random_mix();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at 5 ms, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mbssoc_ram_arb.md
Name: mbssoc_ram_arb

Overview:
- Two-requester arbiter and sequencer in front of the shared SoC RAM.
- Requester 0 is instruction fetch (read-only); requester 1 is the load/store data port.
- Converts each requester's valid/ready transaction into the RAM's protocol: registered read address, a tristated shared data bus, and ram_we/ram_re strobes.
- Round-robin grant, so neither requester can starve the other.

Parameters:
- AW, `ADDR_WIDTH: byte address width, passed through unchanged; the RAM does the word indexing.
- DW, `DATA_WIDTH: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DW  fetch data, held until the next if_ack.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DW  load data, held until the next d_ack.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read-output enable.
- ram_addr  out  AW  RAM byte address.
- ram_data  inout  DW  shared RAM data bus.

Behaviour:
- Reset (asynchronous on rst_n low) forces:
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie);
  - ram_we = ram_re = 0, ram_addr = 0, ram_data = Z;
  - if_ack = d_ack = 0, if_rdata = d_rdata = 0.
- Request hold rule: a requester keeps req and its address/data stable until its ack. Dropping req before ack is illegal; the result is undefined, with no hang beyond the current transaction.
- State machine (one-hot or encoded; transitions on the rising edge of clk):
  - IDLE:
    - If only one requester asserts req, grant it.
    - If both assert req, grant the one that is not last_grant.
    - On grant, latch the winner's id, addr, we and wdata into internal regs, and update last_grant.
    - Go to WR if the winner is requester 1 with d_we = 1; otherwise go to RD_ADDR.
  - RD_ADDR: drive ram_addr = latched addr, ram_re = 0. On the clock edge the RAM registers the address. Go to RD_DATA.
  - RD_DATA: drive ram_re = 1, ram_data = Z, and sample ram_data at the clock edge.
    - Load the sample into if_rdata or d_rdata according to the latched id.
    - Pulse that requester's ack in the following cycle (DONE).
  - WR: drive ram_addr, ram_data = latched wdata and ram_we = 1 for exactly one cycle; the RAM writes at the edge. Go to DONE.
  - DONE: drive the granted requester's ack = 1 for one cycle; all RAM strobes are 0 and ram_data = Z. Return to IDLE.
- Latency from the IDLE cycle in which req is seen to the ack cycle:
  - read: 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE);
  - write: 3 cycles (IDLE, WR, DONE).
  - There are no back-to-back bypasses.
- Bus ownership:
  - ram_data is driven only in WR.
  - ram_re and ram_we are never high in the same cycle.
  - ram_re is high only in RD_DATA, which prevents a bus fight with the RAM.
- Requests arriving in non-IDLE states wait; they are evaluated only in IDLE.
- Both requesters continuously requesting are served strictly alternately: fetch, data, fetch, data, …
- ram_addr holds its last value outside transactions and is not cleared.
- Widths: addresses pass through unchanged, with no truncation or alignment checking. Misaligned low bits are ignored by the RAM's >>2.
- Reset mid-transaction aborts immediately:
  - strobes go low and the bus goes to Z;
  - no ack is issued;
  - a partially sequenced write that had not reached its WR edge is not performed.

Decomposition:
- Shared package / const header: state encodings (ARB_IDLE, ARB_RD_ADDR, ARB_RD_DATA, ARB_WR, ARB_DONE) and requester ids (ARB_ID_IF = 0, ARB_ID_D = 1), added alongside `ADDR_WIDTH/`DATA_WIDTH.
- Sub-module mbssoc_rr_pick2: combinational two-way round-robin picker with inputs req[1:0] and last, outputs grant and id. It is small but reusable for future bus masters.
- FSM, latches and tristate stay in the top.

Test Plan:
- Single read: preload word 3 with 0xDEADBEEF; if_req with if_addr = 0x0C. Expect ram_re high only in cycle 3, if_ack in cycle 4, if_rdata = 0xDEADBEEF, d_ack never asserted.
- Single write then read: d_req, d_we = 1, d_addr = 0x10, d_wdata = 0x12345678. Expect ram_we for one cycle and d_ack at cycle 3. Then a data read of 0x10 returns 0x12345678 with d_ack at cycle 4.
- Contention: if_req and d_req held from reset, both reading different preloaded words. Expect grants in the order IF, D, IF, D, each with its correct data, and no ack overlap.
- Write/read hazard: d write of 0xA5A5A5A5 to 0x20, with if_req reading 0x20 asserted in the same cycle. IF wins the first tie and returns the old value; a repeat IF read after d_ack returns 0xA5A5A5A5.
- Bus integrity assertion over a 10k-cycle random mix:
  - never ram_we & ram_re;
  - ram_data is driven by the arbiter only in WR;
  - every req gets exactly one ack.
- Reset mid-write: assert rst_n low during the WR cycle of a write to 0x30. Expect all outputs at reset values asynchronously, no d_ack, and an FSM returning to IDLE after release.
